// File: rtl/prbs7_xnor_checker.sv
// PRBS7 (x^7+x^6+1, XNOR feedback) serial checker with self-synchronizing hunt,
// free-running reference once locked, and a saturating error counter.
module prbs7_xnor_checker #(
    parameter int LOCK_CNT  = 16,
    parameter int LOSS_ERRS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din_valid,
    input  logic        din,
    input  logic        err_clr,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_cnt
);

    typedef enum logic [1:0] {FILL, HUNT, LOCKED} state_t;

    localparam logic [7:0] LOCK_N = 8'(LOCK_CNT);
    localparam logic [3:0] LOSS_N = 4'(LOSS_ERRS);

    state_t      state, state_nxt;
    logic [6:0]  sr, sr_nxt;
    logic [2:0]  fill_cnt, fill_nxt;
    logic [7:0]  match_cnt, match_nxt;
    logic [3:0]  miss_cnt, miss_nxt;
    logic        locked_nxt, pulse_nxt;
    logic [15:0] cnt_nxt;
    logic        exp_bit, mismatch;

    assign exp_bit  = ~(sr[6] ^ sr[5]);
    assign mismatch = din ^ exp_bit;

    always_comb begin
        state_nxt  = state;
        sr_nxt     = sr;
        fill_nxt   = fill_cnt;
        match_nxt  = match_cnt;
        miss_nxt   = miss_cnt;
        locked_nxt = locked;
        pulse_nxt  = 1'b0;
        cnt_nxt    = err_cnt;
        if (din_valid) begin
            case (state)
                FILL: begin
                    sr_nxt = {sr[5:0], din};
                    if (fill_cnt == 3'd6) begin
                        fill_nxt  = 3'd0;
                        match_nxt = 8'd0;
                        state_nxt = HUNT;
                    end else begin
                        fill_nxt = fill_cnt + 3'd1;
                    end
                end
                HUNT: begin
                    sr_nxt = {sr[5:0], din};
                    // The all-ones register is the XNOR lockup point and never counts as a match.
                    if (!mismatch && sr != 7'h7F) begin
                        if (match_cnt + 8'd1 == LOCK_N) begin
                            match_nxt  = 8'd0;
                            miss_nxt   = 4'd0;
                            locked_nxt = 1'b1;
                            state_nxt  = LOCKED;
                        end else begin
                            match_nxt = match_cnt + 8'd1;
                        end
                    end else begin
                        match_nxt = 8'd0;
                    end
                end
                LOCKED: begin
                    sr_nxt = {sr[5:0], exp_bit};
                    if (mismatch) begin
                        pulse_nxt = 1'b1;
                        if (err_cnt != 16'hFFFF) cnt_nxt = err_cnt + 16'd1;
                        if (miss_cnt + 4'd1 == LOSS_N) begin
                            miss_nxt   = 4'd0;
                            fill_nxt   = 3'd0;
                            locked_nxt = 1'b0;
                            state_nxt  = FILL;
                        end else begin
                            miss_nxt = miss_cnt + 4'd1;
                        end
                    end else begin
                        miss_nxt = 4'd0;
                    end
                end
                default: begin
                    state_nxt  = FILL;
                    fill_nxt   = 3'd0;
                    locked_nxt = 1'b0;
                end
            endcase
        end
        if (err_clr) cnt_nxt = 16'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            sr        <= 7'd0;
            fill_cnt  <= 3'd0;
            match_cnt <= 8'd0;
            miss_cnt  <= 4'd0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= 16'd0;
        end else begin
            state     <= state_nxt;
            sr        <= sr_nxt;
            fill_cnt  <= fill_nxt;
            match_cnt <= match_nxt;
            miss_cnt  <= miss_nxt;
            locked    <= locked_nxt;
            err_pulse <= pulse_nxt;
            err_cnt   <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_prbs7_xnor_checker.sv
// Directed bench for prbs7_xnor_checker: default instance plus a LOSS_ERRS=15 instance for saturation.
module tb_prbs7_xnor_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        din_valid = 1'b0, din = 1'b0, err_clr = 1'b0;
    logic        locked, err_pulse;
    logic [15:0] err_cnt;
    logic        s_valid = 1'b0, s_din = 1'b0, s_clr = 1'b0;
    logic        s_locked, s_pulse;
    logic [15:0] s_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [6:0]  gen, gen_s;

    always #5 clk = ~clk;

    prbs7_xnor_checker dut (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .err_clr(err_clr),
        .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt)
    );

    prbs7_xnor_checker #(.LOCK_CNT(16), .LOSS_ERRS(15)) dut_sat (
        .clk(clk), .rst_n(rst_n), .din_valid(s_valid), .din(s_din), .err_clr(s_clr),
        .locked(s_locked), .err_pulse(s_pulse), .err_cnt(s_cnt)
    );

    function automatic logic prbs_out(input logic [6:0] g);
        return ~(g[6] ^ g[5]);
    endfunction

    task automatic next_bit(output logic b);
        b = prbs_out(gen);
        gen = {gen[5:0], b};
    endtask

    task automatic drive(input logic v, input logic d, input logic clr);
        din_valid = v; din = d; err_clr = clr;
        @(posedge clk); #1;
        din_valid = 1'b0; err_clr = 1'b0;
    endtask

    task automatic send_clean(input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            next_bit(b);
            drive(1'b1, b, 1'b0);
        end
    endtask

    task automatic drive_s(input logic d);
        logic b;
        b = prbs_out(gen_s);
        gen_s = {gen_s[5:0], b};
        s_valid = 1'b1; s_din = b ^ d;
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %0b want 0", locked); end
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got %0b want 0", err_pulse); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0h want 0", err_cnt); end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_clean_lock;
        logic b;
        int pulses = 0;
        gen = 7'h00;
        send_clean(22);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_early got %0b want 0", locked); end
        send_clean(1);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_23 got %0b want 1", locked); end
        for (int i = 0; i < 1000; i++) begin
            next_bit(b);
            drive(1'b1, b, 1'b0);
            if (err_pulse) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL clean_pulses got %0d want 0", pulses); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL clean_cnt got %0h want 0", err_cnt); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL clean_locked got %0b want 1", locked); end
    endtask

    task automatic test_single_error;
        logic b;
        int pulses = 0;
        next_bit(b);
        drive(1'b1, ~b, 1'b0);
        checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL single_pulse got %0b want 1", err_pulse); end
        checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL single_cnt got %0h want 1", err_cnt); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL single_locked got %0b want 1", locked); end
        send_clean(1);
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL single_pulse_width got %0b want 0", err_pulse); end
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                next_bit(b);
                drive(1'b1, b, 1'b0);
            end else begin
                drive(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            end
            if (err_pulse) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL gap_pulses got %0d want 0", pulses); end
        checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL gap_cnt got %0h want 1", err_cnt); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL gap_locked got %0b want 1", locked); end
    endtask

    task automatic test_err_clr;
        logic b;
        next_bit(b);
        drive(1'b1, ~b, 1'b1);
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL clr_cnt got %0h want 0", err_cnt); end
        checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL clr_pulse got %0b want 1", err_pulse); end
        send_clean(1);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL clr_locked got %0b want 1", locked); end
    endtask

    task automatic test_loss_relock;
        logic b;
        for (int i = 0; i < 3; i++) begin
            next_bit(b);
            drive(1'b1, ~b, 1'b0);
        end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL loss_3_locked got %0b want 1", locked); end
        checks++; if (err_cnt !== 16'd3) begin errors++; $display("FAIL loss_3_cnt got %0h want 3", err_cnt); end
        next_bit(b);
        drive(1'b1, ~b, 1'b0);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL loss_4_locked got %0b want 0", locked); end
        checks++; if (err_cnt !== 16'd4) begin errors++; $display("FAIL loss_4_cnt got %0h want 4", err_cnt); end
        checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL loss_4_pulse got %0b want 1", err_pulse); end
        send_clean(22);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL relock_early got %0b want 0", locked); end
        send_clean(1);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL relock_23 got %0b want 1", locked); end
        checks++; if (err_cnt !== 16'd4) begin errors++; $display("FAIL relock_cnt got %0h want 4", err_cnt); end
    endtask

    task automatic test_reset_in_lock;
        logic b;
        next_bit(b);
        drive(1'b1, ~b, 1'b0);
        checks++; if (err_cnt !== 16'd5) begin errors++; $display("FAIL pre_rst_cnt got %0h want 5", err_cnt); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rst_lock_locked got %0b want 0", locked); end
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL rst_lock_pulse got %0b want 0", err_pulse); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL rst_lock_cnt got %0h want 0", err_cnt); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        gen = 7'h15;
        send_clean(22);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rst_relock_early got %0b want 0", locked); end
        send_clean(1);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL rst_relock_23 got %0b want 1", locked); end
    endtask

    task automatic test_lockup;
        int locks = 0;
        int pulses = 0;
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            drive(1'b1, 1'b1, 1'b0);
            if (locked) locks++;
            if (err_pulse) pulses++;
        end
        checks++; if (locks != 0) begin errors++; $display("FAIL lockup_locked got %0d want 0", locks); end
        checks++; if (pulses != 0) begin errors++; $display("FAIL lockup_pulses got %0d want 0", pulses); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL lockup_cnt got %0h want 0", err_cnt); end
    endtask

    task automatic test_saturation;
        int pulses = 0;
        gen_s = 7'h00;
        for (int i = 0; i < 23; i++) drive_s(1'b0);
        checks++; if (s_locked !== 1'b1) begin errors++; $display("FAIL sat_lock got %0b want 1", s_locked); end
        // 14 errors then one clean bit keeps the 15-error loss threshold out of reach.
        for (int g = 0; g < 4682; g++) begin
            for (int i = 0; i < 14; i++) begin
                drive_s(1'b1);
                if (s_pulse) pulses++;
            end
            drive_s(1'b0);
            if (s_pulse) pulses++;
            if (g == 0) begin
                checks++; if (s_cnt !== 16'd14) begin errors++; $display("FAIL sat_first_group got %0h want e", s_cnt); end
            end
        end
        checks++; if (pulses != 65548) begin errors++; $display("FAIL sat_pulses got %0d want 65548", pulses); end
        checks++; if (s_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_cnt got %0h want ffff", s_cnt); end
        checks++; if (s_locked !== 1'b1) begin errors++; $display("FAIL sat_locked got %0b want 1", s_locked); end
    endtask

    initial begin
        test_reset;
        test_clean_lock;
        test_single_error;
        test_err_clr;
        test_loss_relock;
        test_reset_in_lock;
        test_lockup;
        test_saturation;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
